// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    // FETCH: issuing; STALL: out of credit; FLUSH: draining stale responses
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetchState_e;

    localparam int          PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: synchronous FIFO with synchronous clear and an
// occupancy count. The head reads as zero when empty.
module ifetch_fifo #(
    parameter int  DW    = 64,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] pushData,
    input  logic          pop,
    output logic [DW-1:0] headData,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rdPtr;
    logic [AW-1:0] wrPtr;

    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign headData = empty ? '0 : mem[rdPtr];

    // Pointers and count; clear wins over any push/pop in the same cycle
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the head output is masked while empty
    always_ff @(posedge Clk) begin
        if (push && !clear) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential fetch with a credit limit shared
// between in-flight requests and buffered instructions, redirect with
// discard of stale responses.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int               DEPTH    = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    output logic             ImemReq,
    output logic [WIDTH-1:0] ImemAddr,
    input  logic             ImemReady,
    input  logic             ImemRvalid,
    input  logic [WIDTH-1:0] ImemRdata,
    output logic             InstrValid,
    output logic [WIDTH-1:0] InstrOut,
    output logic [WIDTH-1:0] InstrPc,
    input  logic             InstrReady,
    input  logic             Redirect,
    input  logic [WIDTH-1:0] RedirectPc
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          CW1     = CW + 1;
    localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

    fetchState_e        state, stateNext;
    logic [WIDTH-1:0]   fetchPc, rspPc, redirectAligned;
    logic [CW-1:0]      outstanding, discardCnt, bufCount, inFlightNext;
    logic [CW:0]        occupancy;
    logic [2*WIDTH-1:0] headData;
    logic               accept, rsp, push, pop, credit, bufEmpty;
    logic [1:0]         unusedPcLsbs;

    assign unusedPcLsbs    = RedirectPc[1:0];
    assign redirectAligned = {RedirectPc[WIDTH-1:2], 2'b00};

    assign occupancy = {1'b0, outstanding} + {1'b0, bufCount};
    assign pop       = InstrValid && InstrReady;
    // A pop this cycle frees a slot at this edge, so it counts as credit;
    // this is what sustains one instruction per cycle.
    assign credit    = (occupancy < DEPTH_C) || pop;

    assign ImemReq  = Rst && (state != FLUSH) && credit && !Redirect;
    assign ImemAddr = fetchPc;
    assign accept   = ImemReq && ImemReady;
    // Responses with nothing in flight are ignored
    assign rsp      = ImemRvalid && (outstanding != '0);
    assign push     = rsp && (discardCnt == '0) && !Redirect;

    // While flushing every in-flight request is stale, so the in-flight
    // count after this edge is also the number of responses to discard.
    assign inFlightNext = outstanding + CW'(accept) - CW'(rsp);

    // Next-state logic; redirect overrides everything
    always_comb begin
        stateNext = state;
        if (Redirect) begin
            stateNext = (inFlightNext != '0) ? FLUSH : FETCH;
        end else begin
            case (state)
                FETCH:   if (!credit) stateNext = STALL;
                STALL:   if (credit)  stateNext = FETCH;
                FLUSH:   if (rsp && discardCnt == CW'(1)) stateNext = FETCH;
                default: stateNext = FETCH;
            endcase
        end
    end

    // State, PCs and in-flight bookkeeping
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= FETCH;
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            outstanding <= '0;
            discardCnt  <= '0;
        end else begin
            state       <= stateNext;
            outstanding <= inFlightNext;
            if (Redirect) begin
                fetchPc    <= redirectAligned;
                rspPc      <= redirectAligned;
                discardCnt <= inFlightNext;
            end else begin
                if (accept) fetchPc <= fetchPc + WIDTH'(PC_INCR);
                if (push)   rspPc   <= rspPc + WIDTH'(PC_INCR);
                if (rsp && discardCnt != '0) discardCnt <= discardCnt - 1'b1;
            end
        end
    end

    ifetch_fifo #(.DW(2 * WIDTH), .DEPTH(DEPTH)) uFifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .clear    (Redirect),
        .push     (push),
        .pushData ({ImemRdata, rspPc}),
        .pop      (pop && !Redirect),
        .headData (headData),
        .count    (bufCount),
        .empty    (bufEmpty)
    );

    assign InstrValid = !bufEmpty;
    assign InstrOut   = headData[2*WIDTH-1:WIDTH];
    assign InstrPc    = headData[WIDTH-1:0];

    // Memory must never answer when nothing is in flight
    assert property (@(posedge Clk) disable iff (!Rst) !(ImemRvalid && outstanding == '0));

endmodule
